// File: rtl/motor_cmd_ramp.sv
// rtl/motor_cmd_ramp.sv - throttle command arming, slew limiting and timeout failsafe feeding pwm_generator x_in
// Optional idle floor while ARMED is enabled by defining MOTOR_IDLE_EN.
module motor_cmd_ramp #(
  parameter int UPDATE_DIV     = 105088,
  parameter int ARM_FRAMES     = 250,
  parameter int SLEW_STEP      = 2,
  parameter int TIMEOUT_FRAMES = 50,
  parameter int MAX_CMD        = 114,
  parameter int IDLE_CMD       = 6
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       arm_in,
  input  logic       cmd_valid_in,
  input  logic [7:0] cmd_in,
  output logic       cmd_ready_out,
  output logic [7:0] x_out,
  output logic       armed_out,
  output logic       failsafe_out,
  output logic       tick_out
);
  localparam int TW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam int AW = $clog2(ARM_FRAMES + 1);
  localparam int OW = $clog2(TIMEOUT_FRAMES + 1);
`ifdef MOTOR_IDLE_EN
  localparam bit IDLE_EN = 1'b1;
`else
  localparam bit IDLE_EN = 1'b0;
`endif
  localparam logic [7:0] MAX8   = 8'(MAX_CMD);
  localparam logic [8:0] MAX9   = 9'(MAX_CMD);
  localparam logic [7:0] SLEW8  = 8'(SLEW_STEP);
  localparam logic [8:0] SLEW9  = 9'(SLEW_STEP);
  localparam logic [8:0] FLOOR9 = IDLE_EN ? 9'(IDLE_CMD) : 9'd0;

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMING   = 2'd1,
    S_ARMED    = 2'd2,
    S_FAILSAFE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt_q;
  logic [AW-1:0] arm_cnt_q, arm_cnt_d;
  logic [OW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    x_q, x_d, target_q, target_d;
  logic          tick, accept;
  logic [8:0]    x9, eff9, diff9, step9, next9;
  logic [7:0]    x_slew, x_down, cmd_clamped;

  // Frame-rate tick counter runs regardless of state.
  assign tick = (tick_cnt_q == TW'(UPDATE_DIV - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
    end
  end

  assign cmd_ready_out = (state_q == S_ARMING) || (state_q == S_ARMED);
  assign accept        = cmd_valid_in & cmd_ready_out;
  assign cmd_clamped   = (cmd_in > MAX8) ? MAX8 : cmd_in;
  assign x_down        = (x_q > SLEW8) ? (x_q - SLEW8) : 8'd0;

  // Slew toward the registered target; a same-cycle accept only affects later ticks.
  always_comb begin
    x9    = {1'b0, x_q};
    eff9  = ({1'b0, target_q} > FLOOR9) ? {1'b0, target_q} : FLOOR9;
    diff9 = '0;
    step9 = '0;
    next9 = x9;
    if (x9 < eff9) begin
      diff9 = eff9 - x9;
      step9 = (diff9 > SLEW9) ? SLEW9 : diff9;
      next9 = x9 + step9;
    end else if (x9 > eff9) begin
      diff9 = x9 - eff9;
      step9 = (diff9 > SLEW9) ? SLEW9 : diff9;
      next9 = x9 - step9;
    end
    x_slew = (next9 > MAX9) ? MAX8 : next9[7:0];
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    target_d  = target_q;
    arm_cnt_d = arm_cnt_q;
    to_cnt_d  = to_cnt_q;
    case (state_q)
      S_DISARMED: begin
        x_d       = '0;
        target_d  = '0;
        arm_cnt_d = '0;
        to_cnt_d  = '0;
        if (arm_in) state_d = S_ARMING;
      end
      S_ARMING: begin
        x_d = '0;
        if (!arm_in) begin
          state_d  = S_DISARMED;
          target_d = '0;
        end else begin
          if (accept) target_d = cmd_clamped;
          if (tick) begin
            arm_cnt_d = arm_cnt_q + AW'(1);
            if (arm_cnt_q == AW'(ARM_FRAMES - 1)) begin
              state_d  = S_ARMED;
              to_cnt_d = '0;
            end
          end
        end
      end
      S_ARMED: begin
        if (!arm_in) begin
          state_d  = S_DISARMED;
          x_d      = '0;
          target_d = '0;
        end else begin
          if (tick) x_d = x_slew;
          if (accept) begin
            target_d = cmd_clamped;
            to_cnt_d = '0;
          end else if (tick) begin
            to_cnt_d = to_cnt_q + OW'(1);
            if (to_cnt_q == OW'(TIMEOUT_FRAMES - 1)) begin
              state_d  = S_FAILSAFE;
              target_d = '0;
            end
          end
        end
      end
      S_FAILSAFE: begin
        target_d = '0;
        if (!arm_in) begin
          state_d = S_DISARMED;
          x_d     = '0;
        end else if (tick) begin
          x_d = x_down;
        end
      end
      default: begin
        state_d  = S_DISARMED;
        x_d      = '0;
        target_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_DISARMED;
      x_q       <= '0;
      target_q  <= '0;
      arm_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      target_q  <= target_d;
      arm_cnt_q <= arm_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign x_out        = x_q;
  assign armed_out    = (state_q == S_ARMED);
  assign failsafe_out = (state_q == S_FAILSAFE);
  assign tick_out     = tick;
endmodule

// File: doc/motor_cmd_ramp.md
Name: motor_cmd_ramp

Overview:
- Upstream feeder for pwm_generator. Produces its 8-bit x_in pulse-width control value from flight-controller throttle commands.
- Enforces the ESC arming sequence (zero throttle held for N PWM frames), slew-rate limiting and command-timeout failsafe.
- x_out changes only on update ticks aligned to the PWM frame rate.

Parameters:
- UPDATE_DIV, 105088, clk_in cycles per update tick (one PWM frame = 821*128).
- ARM_FRAMES, 250, ticks of zero output held in ARMING before ARMED.
- SLEW_STEP, 2, max |change| of x_out per tick.
- TIMEOUT_FRAMES, 50, ticks without an accepted command in ARMED before FAILSAFE.
- MAX_CMD, 114, clamp ceiling for target (pwm_generator counter is 7 bits, offset 13).
- IDLE_CMD, 6, idle floor; used only with MOTOR_IDLE_EN.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset; asynchronous, active-low
- arm_in  input  1  level; 1 = request armed, 0 = disarm
- cmd_valid_in  input  1  command valid
- cmd_in  input  8  requested throttle, unsigned
- cmd_ready_out  output  1  command accept; 1 only in ARMING or ARMED
- x_out  output  8  to pwm_generator x_in; registered
- armed_out  output  1  1 in ARMED
- failsafe_out  output  1  1 in FAILSAFE
- tick_out  output  1  one-cycle update-tick pulse

Behaviour:
- Reset (async assert, sync release): state DISARMED; x_out=0, target=0, all counters 0; armed_out, failsafe_out and tick_out 0. Reset mid-ramp drops x_out to 0 immediately.
- Tick counter: counts 0..UPDATE_DIV-1 and wraps. tick_out=1 on the cycle the count equals UPDATE_DIV-1. First tick occurs UPDATE_DIV cycles after reset release. Free-running in all states.
- Handshake: command accepted when cmd_valid_in & cmd_ready_out. Accepted value goes to target = min(cmd_in, MAX_CMD) next cycle. No backpressure beyond state gating. Commands presented while cmd_ready_out=0 are dropped, not queued.
- DISARMED:
  - x_out=0, target=0.
  - arm_in=1 → ARMING; arm counter cleared.
- ARMING:
  - x_out=0. Target cleared on entry; commands are accepted into target.
  - Each tick increments the arm counter. On the tick where the count reaches ARM_FRAMES → ARMED; timeout counter cleared.
  - arm_in=0 → DISARMED next cycle (higher priority than completion).
- ARMED:
  - Each tick: if x_out<target, x_out += min(SLEW_STEP, target-x_out). If x_out>target, x_out -= min(SLEW_STEP, x_out-target). Otherwise hold.
  - Arithmetic in 9 bits; x_out never leaves 0..MAX_CMD.
  - Slew uses the target registered before any same-cycle accept.
  - Timeout counter: +1 per tick, cleared on accept. Accept on the same cycle as a tick clears it (accept wins). Count reaching TIMEOUT_FRAMES → FAILSAFE.
  - arm_in=0 → DISARMED with x_out=0 next cycle. No ramp-down.
- FAILSAFE:
  - cmd_ready_out=0, target forced 0. x_out ramps down by SLEW_STEP per tick to 0 and stays there.
  - Exit only via arm_in=0 → DISARMED. Re-arming then requires the full ARMING sequence.
- armed_out and failsafe_out are decoded from registered state, with no combinational path from inputs.
- Illegal state encoding → DISARMED.

Optional Feature:
- Macro MOTOR_IDLE_EN.
- Defined: in ARMED, effective target = max(target, IDLE_CMD). On entering ARMED, x_out ramps from 0 to IDLE_CMD at SLEW_STEP per tick. FAILSAFE and DISARMED still go to 0.
- Undefined: no floor; IDLE_CMD unused. Behaviour exactly as above.

Test Plan:
Sim params: UPDATE_DIV=4, ARM_FRAMES=3, SLEW_STEP=2, TIMEOUT_FRAMES=5, MAX_CMD=114.
- Arming: arm_in=1 from reset, cmd 0 each tick → x_out=0 through 3 ticks; armed_out rises after 3rd tick (~cycle 12); cmd_ready_out 0 in DISARMED.
- Ramp/clamp: ARMED, cmd_in=200 accepted → target 114; x_out goes 2,4,6,... by 2 per tick, reaching 114 after 57 ticks. Then cmd_in=109 → 112,110,109,109.
- Timeout: ARMED at x_out=20, stop commands → failsafe_out=1 on 5th tick; x_out 18,16,...,0; cmd_valid_in ignored with cmd_ready_out=0; arm_in=0 → DISARMED; arm_in=1 → full 3-tick ARMING again.
- Simultaneous: accept coincident with the 5th timeout tick → stays ARMED, counter 0. arm_in=0 on the cycle ARMING completes → DISARMED, armed_out never asserts.
- Reset mid-op: rst_n_in low asynchronously at x_out=60 → x_out=0, state DISARMED, tick counter restarts; first tick_out 4 cycles after release.
- MOTOR_IDLE_EN (IDLE_CMD=6): arm with cmd 0 → x_out 2,4,6 then holds 6. Timeout → ramps to 0.
